// File: rtl/md_alu_pkg.sv
// Shared op codes, FSM state encoding and defaults for md_alu.
package md_alu_pkg;

  localparam int OPW_DEFAULT = 4;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_OR    = 2;
  localparam int OP_AND   = 3;
  localparam int OP_SLT   = 4;
  localparam int OP_SLTU  = 5;
  localparam int OP_MULTU = 6;
  localparam int OP_DIVU  = 7;
  localparam int OP_MTHI  = 8;
  localparam int OP_MTLO  = 9;
  localparam int OP_MULT  = 10;
  localparam int OP_DIV   = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/md_iter_core.sv
// Iterative shift-add multiply / restoring divide datapath, one bit per cycle.
// nxt_hi/nxt_lo are the register values after the current iteration.
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  // acc_lo holds the multiplier (mul) or the dividend/quotient (div);
  // acc_hi is the upper product half or the partial remainder.
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - opb;
    nxt_hi  = sum[WIDTH:1];
    nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
    if (div) begin
      if (shifted >= {1'b0, opb}) begin
        nxt_hi = diff;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
    last = (cnt == CW'(WIDTH - 1));
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (load) begin
      opb    <= b_in;
      acc_lo <= a_in;
      acc_hi <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/md_alu.sv
// EX-stage ALU with combinational ops plus iterative mul/div and HI/LO.
// Define MD_SIGNED_EN to enable signed MULT (10) and DIV (11).
module md_alu
  import md_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = OPW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  input  logic             start,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MSB = WIDTH - 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sum_ab, dif_ab;
  logic             idle, go_mul, go_div, go_mthi, go_mtlo, signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] nxt_hi, nxt_lo, res_hi, res_lo;
  logic             last;

  always_comb begin
    sum_ab   = a + b;
    dif_ab   = a - b;
    aluout   = '0;
    overflow = 1'b0;
    case (op)
      OPW'(OP_ADD): begin
        aluout   = sum_ab;
        overflow = (a[MSB] == b[MSB]) && (sum_ab[MSB] != a[MSB]);
      end
      OPW'(OP_SUB): begin
        aluout   = dif_ab;
        overflow = (a[MSB] != b[MSB]) && (dif_ab[MSB] != a[MSB]);
      end
      OPW'(OP_OR):   aluout = a | b;
      OPW'(OP_AND):  aluout = a & b;
      OPW'(OP_SLT):  aluout = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OPW'(OP_SLTU): aluout = {{(WIDTH-1){1'b0}}, a < b};
      default: ;
    endcase
    zero = (aluout == '0);
  end

  // Launch decode; start only matters in IDLE.
  always_comb begin
    idle      = (state_q == ST_IDLE);
    signed_op = 1'b0;
    go_mul    = idle && start && (op == OPW'(OP_MULTU));
    go_div    = idle && start && (op == OPW'(OP_DIVU));
    go_mthi   = idle && start && (op == OPW'(OP_MTHI));
    go_mtlo   = idle && start && (op == OPW'(OP_MTLO));
`ifdef MD_SIGNED_EN
    signed_op = (op == OPW'(OP_MULT)) || (op == OPW'(OP_DIV));
    if (idle && start && (op == OPW'(OP_MULT))) go_mul = 1'b1;
    if (idle && start && (op == OPW'(OP_DIV)))  go_div = 1'b1;
`endif
    a_mag = (signed_op && a[MSB]) ? -a : a;
    b_mag = (signed_op && b[MSB]) ? -b : b;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (go_mul)      state_d = ST_MUL;
        else if (go_div) state_d = ST_DIV;
      end
      ST_MUL, ST_DIV: if (last) state_d = ST_DONE;
      ST_DONE:        state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
    busy = (state_q == ST_MUL) || (state_q == ST_DIV);
    done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .reset  (reset),
    .load   (go_mul || go_div),
    .step   (busy),
    .div    (state_q == ST_DIV),
    .a_in   (a_mag),
    .b_in   (b_mag),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo),
    .last   (last)
  );

`ifdef MD_SIGNED_EN
  logic               neg_q, neg_r, div0;
  logic [2*WIDTH-1:0] prod_neg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else if (go_mul || go_div) begin
      neg_q <= signed_op && (a[MSB] ^ b[MSB]);
      neg_r <= signed_op && a[MSB];
      div0  <= (b == '0);
    end
  end

  // Sign fix-up on the final iteration; a zero divisor keeps the all-ones quotient.
  always_comb begin
    prod_neg = -{nxt_hi, nxt_lo};
    res_hi   = nxt_hi;
    res_lo   = nxt_lo;
    if (state_q == ST_MUL) begin
      if (neg_q) {res_hi, res_lo} = prod_neg;
    end else begin
      if (neg_q && !div0) res_lo = -nxt_lo;
      if (neg_r)          res_hi = -nxt_hi;
    end
  end
`else
  always_comb begin
    res_hi = nxt_hi;
    res_lo = nxt_lo;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (busy && last) begin
      hi <= res_hi;
      lo <= res_lo;
    end else begin
      if (go_mthi) hi <= a;
      if (go_mtlo) lo <= a;
    end
  end

endmodule

// File: tb/tb_md_alu.sv
// Directed self-checking bench for md_alu: combinational vector table plus
// mul/div handshake, MTHI/MTLO, reset-abort and optional signed sequences.
module tb_md_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic        start;
  logic [31:0] aluout, hi, lo;
  logic        zero, overflow, busy, done;

  int checks   = 0;
  int failures = 0;

  md_alu dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .start(start),
    .aluout(aluout), .zero(zero), .overflow(overflow),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] y;
    logic        z;
    logic        v;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_md(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el,
                        input bit scramble, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    a = av; b = bv; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (busy && n < 100) begin
      n++;
      if (scramble && n == 5) begin
        a = $urandom; b = $urandom; op = 4'd6; start = 1'b1;
      end else if (scramble && n == 6) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({nm, " busy_cycles"}, 64'(n), 64'd32);
    check({nm, " done"}, 64'(done), 64'd1);
    check({nm, " hi"}, 64'(hi), 64'(eh));
    check({nm, " lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({nm, " done_pulse_end"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin
    tbl[0]  = '{32'd2,         32'd1,          4'd1,  32'd1,         1'b0, 1'b0};
    tbl[1]  = '{32'h7FFFFFFF,  32'd1,          4'd0,  32'h80000000,  1'b0, 1'b1};
    tbl[2]  = '{32'd5,         32'd5,          4'd1,  32'd0,         1'b1, 1'b0};
    tbl[3]  = '{32'h80000000,  32'd1,          4'd1,  32'h7FFFFFFF,  1'b0, 1'b1};
    tbl[4]  = '{32'h0000F0F0,  32'h00000F0F,   4'd2,  32'h0000FFFF,  1'b0, 1'b0};
    tbl[5]  = '{32'h0000F0F0,  32'h00000F0F,   4'd3,  32'd0,         1'b1, 1'b0};
    tbl[6]  = '{32'hFFFFFFFF,  32'd1,          4'd4,  32'd1,         1'b0, 1'b0};
    tbl[7]  = '{32'hFFFFFFFF,  32'd1,          4'd5,  32'd0,         1'b1, 1'b0};
    tbl[8]  = '{32'd3,         32'hFFFFFFFE,   4'd5,  32'd1,         1'b0, 1'b0};
    tbl[9]  = '{32'd5,         32'd5,          4'd6,  32'd0,         1'b1, 1'b0};
    tbl[10] = '{32'd5,         32'd5,          4'd15, 32'd0,         1'b1, 1'b0};
    tbl[11] = '{32'hFFFFFFFF,  32'd1,          4'd0,  32'd0,         1'b1, 1'b0};

    reset = 1'b1; a = '0; b = '0; op = '0; start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset busy/done", 64'({busy, done}), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    for (int i = 0; i < 12; i++) begin
      a = tbl[i].a; b = tbl[i].b; op = tbl[i].op;
      #1;
      check($sformatf("comb[%0d] aluout", i), 64'(aluout), 64'(tbl[i].y));
      check($sformatf("comb[%0d] zero", i), 64'(zero), 64'(tbl[i].z));
      check($sformatf("comb[%0d] overflow", i), 64'(overflow), 64'(tbl[i].v));
    end

    run_md(4'd6, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 1'b0, "multu_ff_x2");
    run_md(4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_max");
    run_md(4'd7, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, "divu_100_7_scrambled");
    run_md(4'd7, 32'd100, 32'd0, 32'd100, 32'hFFFFFFFF, 1'b0, "divu_by_zero");
    run_md(4'd7, 32'hFFFFFFFF, 32'd10, 32'd5, 32'h19999999, 1'b0, "divu_max_10");

    // MTHI/MTLO write at the start edge without busy or done.
    @(negedge clk);
    a = 32'h1234; op = 4'd8; start = 1'b1;
    @(posedge clk); #1;
    check("mthi hi", 64'(hi), 64'h1234);
    check("mthi busy", 64'({busy, done}), 64'd0);
    @(negedge clk);
    a = 32'h5678; op = 4'd9;
    @(posedge clk); #1;
    check("mtlo lo", 64'(lo), 64'h5678);
    check("mtlo hi kept", 64'(hi), 64'h1234);
    start = 1'b0;
    @(negedge clk);
    check("mt busy/done", 64'({busy, done}), 64'd0);

    // Reset ten cycles into a MULTU aborts it immediately.
    a = 32'hFFFFFFFF; b = 32'd2; op = 4'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort busy/done", 64'({busy, done}), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_md(4'd6, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 1'b0, "multu_after_reset");

`ifdef MD_SIGNED_EN
    run_md(4'd10, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4, 1'b0, "mult_m3_4");
    run_md(4'd11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_m7_2");
    run_md(4'd11, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, "div_minneg_m1");
    run_md(4'd11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b0, "div_m7_0");
`else
    @(negedge clk);
    a = 32'd3; b = 32'd4; op = 4'd10; start = 1'b1;
    #1;
    check("op10 aluout", 64'(aluout), 64'd0);
    @(negedge clk);
    start = 1'b0;
    check("op10 busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    check("op10 still idle", 64'({busy, done}), 64'd0);
    check("op10 hi/lo kept", {hi, lo}, {32'd1, 32'hFFFFFFFE});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
